// File: rtl/frog_pkg.sv
// Shared FROG fetch-stage constants and the program-counter type.
package frog_pkg;

  localparam int PC_W = 32;

  typedef logic [PC_W-1:0] pc_t;

  localparam pc_t RESET_PC = 32'h0000_0000;
  localparam pc_t PC_INC   = 32'd4;

endpackage

// File: rtl/pc.sv
// FROG program counter: one register that loads either the sequential successor
// or the ALU-computed branch/jump target on every rising clock edge.
module pc
  import frog_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sel_next_pc_alu_out,
  input  pc_t  alu_out,
  output pc_t  pc_out,
  output pc_t  pc_plus4
);

  pc_t r_pc;
  pc_t w_pc_plus4;
  pc_t w_next_pc;

  // The carry out of the add is dropped, so the top word address wraps to zero.
  assign w_pc_plus4 = r_pc + PC_INC;
  assign w_next_pc  = sel_next_pc_alu_out ? alu_out : w_pc_plus4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  assign pc_out   = r_pc;
  assign pc_plus4 = w_pc_plus4;

`ifndef SYNTHESIS
  // Targets are taken verbatim; misalignment is only a hint that decode went wrong.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!$isunknown(sel_next_pc_alu_out))
        else $error("pc: unknown sel_next_pc_alu_out out of reset");
      if (sel_next_pc_alu_out === 1'b1) begin
        assert (!$isunknown(alu_out))
          else $error("pc: unknown alu_out while it is selected");
      end
      assert (r_pc[1:0] == 2'b00)
        else $warning("pc: misaligned pc 0x%08h", r_pc);
    end
  end
`endif

endmodule

// File: tb/tb_pc.sv
// Self-checking bench for the FROG program counter: directed scenarios plus
// randomized jump/fall-through traffic checked against a plain arithmetic model.
module tb_pc;
  import frog_pkg::*;

  logic clk;
  logic rst;
  logic sel_next_pc_alu_out;
  pc_t  alu_out;
  pc_t  pc_out;
  pc_t  pc_plus4;

  int compared;
  int mismatched;

  // Reference: the address the PC should hold right now.
  logic [31:0] modelPc;

  pc dut (
    .clk                 (clk),
    .rst                 (rst),
    .sel_next_pc_alu_out (sel_next_pc_alu_out),
    .alu_out             (alu_out),
    .pc_out              (pc_out),
    .pc_plus4            (pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, pc_out=%0h required finish", pc_out);
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one rising edge, updating the model, and settle 1 time unit past it.
  task automatic stepEdge();
    @(posedge clk);
    if (rst)
      modelPc = 32'h0;
    else if (sel_next_pc_alu_out)
      modelPc = alu_out;
    else
      modelPc = modelPc + 32'd4;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sel_next_pc_alu_out = 1'b0;
    alu_out = 32'h0;
    for (int i = 0; i < 2; i++) begin
      stepEdge();
      compared++;
      if (pc_out !== 32'h0) begin
        mismatched++;
        $display("[TB] FAIL reset_pc_out edge%0d: got %0h want 0", i, pc_out);
      end
      compared++;
      if (pc_plus4 !== 32'h4) begin
        mismatched++;
        $display("[TB] FAIL reset_pc_plus4 edge%0d: got %0h want 4", i, pc_plus4);
      end
    end
  endtask

  task automatic test_sequential();
    rst = 1'b0;
    sel_next_pc_alu_out = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      stepEdge();
      compared++;
      if (pc_out !== 32'(i * 4)) begin
        mismatched++;
        $display("[TB] FAIL seq_pc_out step%0d: got %0h want %0h", i, pc_out, i * 4);
      end
      compared++;
      if (pc_plus4 !== 32'(i * 4 + 4)) begin
        mismatched++;
        $display("[TB] FAIL seq_pc_plus4 step%0d: got %0h want %0h", i, pc_plus4, i * 4 + 4);
      end
    end
  endtask

  task automatic test_jump();
    logic [31:0] expSeq [3];
    expSeq[0] = 32'd40;
    expSeq[1] = 32'd44;
    expSeq[2] = 32'd48;
    alu_out = 32'd40;
    sel_next_pc_alu_out = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stepEdge();
      sel_next_pc_alu_out = 1'b0;
      alu_out = 32'hDEAD_BEE0;
      compared++;
      if (pc_out !== expSeq[i]) begin
        mismatched++;
        $display("[TB] FAIL jump_pc_out step%0d: got %0h want %0h", i, pc_out, expSeq[i]);
      end
    end
  endtask

  task automatic test_wrap();
    alu_out = 32'hFFFF_FFFC;
    sel_next_pc_alu_out = 1'b1;
    stepEdge();
    sel_next_pc_alu_out = 1'b0;
    compared++;
    if (pc_out !== 32'hFFFF_FFFC) begin
      mismatched++;
      $display("[TB] FAIL wrap_load: got %0h want fffffffc", pc_out);
    end
    compared++;
    if (pc_plus4 !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL wrap_pc_plus4: got %0h want 0", pc_plus4);
    end
    stepEdge();
    compared++;
    if (pc_out !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL wrap_pc_out: got %0h want 0", pc_out);
    end
  endtask

  task automatic test_async_reset();
    alu_out = 32'd40;
    sel_next_pc_alu_out = 1'b1;
    stepEdge();
    sel_next_pc_alu_out = 1'b0;
    stepEdge();
    compared++;
    if (pc_out !== 32'd44) begin
      mismatched++;
      $display("[TB] FAIL async_setup: got %0h want 2c", pc_out);
    end
    #2;
    rst = 1'b1;
    #1;
    modelPc = 32'h0;
    compared++;
    if (pc_out !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL async_immediate: got %0h want 0", pc_out);
    end
    compared++;
    if (pc_plus4 !== 32'h4) begin
      mismatched++;
      $display("[TB] FAIL async_pc_plus4: got %0h want 4", pc_plus4);
    end
    stepEdge();
    rst = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      stepEdge();
      compared++;
      if (pc_out !== 32'(i * 4)) begin
        mismatched++;
        $display("[TB] FAIL async_restart step%0d: got %0h want %0h", i, pc_out, i * 4);
      end
    end
  endtask

  task automatic test_back_to_back();
    sel_next_pc_alu_out = 1'b1;
    alu_out = 32'd100;
    stepEdge();
    compared++;
    if (pc_out !== 32'd100) begin
      mismatched++;
      $display("[TB] FAIL b2b_first: got %0h want 64", pc_out);
    end
    alu_out = 32'd200;
    stepEdge();
    sel_next_pc_alu_out = 1'b0;
    compared++;
    if (pc_out !== 32'd200) begin
      mismatched++;
      $display("[TB] FAIL b2b_second: got %0h want c8", pc_out);
    end
    stepEdge();
    compared++;
    if (pc_out !== 32'd204) begin
      mismatched++;
      $display("[TB] FAIL b2b_fallthrough: got %0h want cc", pc_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 29) == 0);
      sel_next_pc_alu_out = ($urandom_range(0, 3) == 0);
      alu_out = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0)
        alu_out = 32'hFFFF_FFF8 | (32'($urandom_range(0, 1)) << 2);
      stepEdge();
      compared++;
      if (pc_out !== modelPc) begin
        mismatched++;
        $display("[TB] FAIL rand_pc_out iter%0d: got %0h want %0h", i, pc_out, modelPc);
      end
      compared++;
      if (pc_plus4 !== modelPc + 32'd4) begin
        mismatched++;
        $display("[TB] FAIL rand_pc_plus4 iter%0d: got %0h want %0h", i, pc_plus4, modelPc + 32'd4);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    modelPc = 32'h0;
    rst = 1'b1;
    sel_next_pc_alu_out = 1'b0;
    alu_out = 32'h0;
    test_reset();
    test_sequential();
    test_jump();
    test_wrap();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
